// File: rtl/fp_div_generic.sv
// Iterative floating-point divider: restoring division producing one quotient bit per cycle.
// Subnormal inputs are read as zero and subnormal results are flushed to zero; supports four rounding modes.
module fp_div_generic #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   fp_a_in,
    input  logic [EXP_W+MAN_W:0]   fp_b_in,
    input  logic [1:0]             rnd_mode,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   fp_res_out,
    output logic [4:0]             flags
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int N_IT   = MAN_W + 4;
    localparam int CW     = $clog2(N_IT + 1);
    localparam int XW     = EXP_W + 2;
    localparam int BIAS_I = (32'sd1 <<< (EXP_W - 1)) - 32'sd1;
    localparam int EINF_I = (32'sd1 <<< EXP_W) - 32'sd1;

    localparam logic signed [XW-1:0] BIAS_X    = XW'(BIAS_I);
    localparam logic signed [XW-1:0] EXP_INF_X = XW'(EINF_I);
    localparam logic signed [XW-1:0] ONE_X     = XW'(32'sd1);
    localparam logic signed [XW-1:0] ZERO_X    = XW'(32'sd0);
    localparam logic [CW-1:0]        LAST_IT   = CW'(N_IT - 1);
    localparam logic [CW-1:0]        CNT_ONE   = CW'(32'd1);
    localparam logic [W-1:0]         QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_DIVIDE = 3'd2,
        S_ROUND  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]           a_q, a_d, b_q, b_d;
    logic [1:0]             mode_q, mode_d;
    logic                   sign_q, sign_d;
    logic signed [XW-1:0]   exp_q, exp_d;
    logic [MAN_W+1:0]       rem_q, rem_d;
    logic [MAN_W:0]         dvs_q, dvs_d;
    logic [N_IT-1:0]        quo_q, quo_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [W-1:0]           res_q, res_d;
    logic [4:0]             flg_q, flg_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [W-1:0]           out_q, out_d;
    logic [4:0]             flags_q, flags_d;

    logic [EXP_W-1:0]       exp_a, exp_b;
    logic [MAN_W-1:0]       frac_a, frac_b;
    logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic                   is_special, res_sign;
    logic [W-1:0]           sp_res;
    logic [4:0]             sp_flg;

    logic                   rem_ge;
    logic [MAN_W:0]         rem_trim;

    logic                   q_msb, g_bit, r_bit, s_bit, inexact, inc, to_inf;
    logic [MAN_W:0]         mant_k;
    logic [MAN_W+1:0]       mant_sum;
    logic [MAN_W-1:0]       frac_f;
    logic signed [XW-1:0]   exp_n, exp_f;
    logic [W-1:0]           rnd_res;
    logic [4:0]             rnd_flg;

    // Operand classification and special-case result selection
    always_comb begin
        exp_a    = a_q[W-2:MAN_W];
        exp_b    = b_q[W-2:MAN_W];
        frac_a   = a_q[MAN_W-1:0];
        frac_b   = b_q[MAN_W-1:0];
        // a zero exponent field is zero regardless of the fraction (subnormals flushed on input)
        a_zero   = (exp_a == {EXP_W{1'b0}});
        b_zero   = (exp_b == {EXP_W{1'b0}});
        a_nan    = (&exp_a) & (|frac_a);
        b_nan    = (&exp_b) & (|frac_b);
        a_inf    = (&exp_a) & ~(|frac_a);
        b_inf    = (&exp_b) & ~(|frac_b);
        a_snan   = a_nan & ~frac_a[MAN_W-1];
        b_snan   = b_nan & ~frac_b[MAN_W-1];
        res_sign = a_q[W-1] ^ b_q[W-1];
        is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        sp_res   = {res_sign, {(W-1){1'b0}}};
        sp_flg   = 5'b00000;
        if (a_nan | b_nan) begin
            sp_res = QNAN;
            sp_flg = {a_snan | b_snan, 4'b0000};
        end else if ((a_inf & b_inf) | (a_zero & b_zero)) begin
            sp_res = QNAN;
            sp_flg = 5'b10000;
        end else if (a_inf) begin
            sp_res = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            sp_flg = 5'b00000;
        end else if (b_inf) begin
            sp_res = {res_sign, {(W-1){1'b0}}};
            sp_flg = 5'b00000;
        end else if (b_zero) begin
            sp_res = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            sp_flg = 5'b01000;
        end else begin
            sp_res = {res_sign, {(W-1){1'b0}}};
            sp_flg = 5'b00000;
        end
    end

    // One restoring-division step on the partial remainder
    always_comb begin
        rem_ge = (rem_q >= {1'b0, dvs_q});
        if (rem_ge) begin
            rem_trim = (MAN_W+1)'(rem_q - {1'b0, dvs_q});
        end else begin
            rem_trim = rem_q[MAN_W:0];
        end
    end

    // Normalisation, rounding, overflow and underflow of the finished quotient
    always_comb begin
        q_msb = quo_q[N_IT-1];
        if (q_msb) begin
            mant_k = quo_q[N_IT-1:3];
            g_bit  = quo_q[2];
            r_bit  = quo_q[1];
            s_bit  = quo_q[0] | (|rem_q);
            exp_n  = exp_q;
        end else begin
            mant_k = quo_q[N_IT-2:2];
            g_bit  = quo_q[1];
            r_bit  = quo_q[0];
            s_bit  = |rem_q;
            exp_n  = exp_q - ONE_X;
        end
        inexact = g_bit | r_bit | s_bit;
        case (mode_q)
            2'b00:   inc = g_bit & (r_bit | s_bit | mant_k[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = ~sign_q & inexact;
            2'b11:   inc = sign_q & inexact;
            default: inc = 1'b0;
        endcase
        mant_sum = {1'b0, mant_k} + {{(MAN_W+1){1'b0}}, inc};
        if (mant_sum[MAN_W+1]) begin
            frac_f = mant_sum[MAN_W:1];
            exp_f  = exp_n + ONE_X;
        end else begin
            frac_f = mant_sum[MAN_W-1:0];
            exp_f  = exp_n;
        end
        to_inf = (mode_q == 2'b00) | ((mode_q == 2'b10) & ~sign_q) | ((mode_q == 2'b11) & sign_q);
        if (exp_f >= EXP_INF_X) begin
            rnd_flg = 5'b00101;
            if (to_inf) begin
                rnd_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                rnd_res = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            end
        end else if (exp_f <= ZERO_X) begin
            rnd_res = {sign_q, {(W-1){1'b0}}};
            rnd_flg = 5'b00011;
        end else begin
            rnd_res = {sign_q, exp_f[EXP_W-1:0], frac_f};
            rnd_flg = {4'b0000, inexact};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = start ? S_UNPACK : S_IDLE;
            S_UNPACK: state_d = is_special ? S_DONE : S_DIVIDE;
            S_DIVIDE: state_d = (cnt_q == LAST_IT) ? S_ROUND : S_DIVIDE;
            S_ROUND:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next values for each state
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        mode_d = mode_q;
        sign_d = sign_q;
        exp_d  = exp_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        flg_d  = flg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d    = fp_a_in;
                    b_d    = fp_b_in;
                    mode_d = rnd_mode;
                end else begin
                    a_d    = a_q;
                end
            end
            S_UNPACK: begin
                sign_d = res_sign;
                if (is_special) begin
                    res_d = sp_res;
                    flg_d = sp_flg;
                end else begin
                    exp_d = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS_X;
                    rem_d = {1'b0, 1'b1, frac_a};
                    dvs_d = {1'b1, frac_b};
                    quo_d = {N_IT{1'b0}};
                    cnt_d = {CW{1'b0}};
                end
            end
            S_DIVIDE: begin
                rem_d = {rem_trim, 1'b0};
                quo_d = {quo_q[N_IT-2:0], rem_ge};
                cnt_d = cnt_q + CNT_ONE;
            end
            S_ROUND: begin
                res_d = rnd_res;
                flg_d = rnd_flg;
            end
            S_DONE: begin
                res_d = res_q;
            end
            default: begin
                res_d = res_q;
            end
        endcase
    end

    // Output next values: results are published only on the done pulse and held afterwards
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DONE);
        if (state_q == S_DONE) begin
            out_d   = res_q;
            flags_d = flg_q;
        end else begin
            out_d   = out_q;
            flags_d = flags_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            mode_q  <= 2'b00;
            sign_q  <= 1'b0;
            exp_q   <= ZERO_X;
            rem_q   <= {(MAN_W+2){1'b0}};
            dvs_q   <= {(MAN_W+1){1'b0}};
            quo_q   <= {N_IT{1'b0}};
            cnt_q   <= {CW{1'b0}};
            res_q   <= {W{1'b0}};
            flg_q   <= 5'b00000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= {W{1'b0}};
            flags_q <= 5'b00000;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fp_res_out = out_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_fp_div_generic.sv
// Directed bench for fp_div_generic: a double-precision vector table plus hand-written
// sequences for reset abort and start-while-busy on a single-precision instance.
module tb_fp_div_generic;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        d_start = 1'b0;
    logic [63:0] d_a = 64'h0, d_b = 64'h0;
    logic [1:0]  d_mode = 2'b00;
    logic        d_busy, d_done;
    logic [63:0] d_res;
    logic [4:0]  d_flags;

    logic        s_start = 1'b0;
    logic [31:0] s_a = 32'h0, s_b = 32'h0;
    logic [1:0]  s_mode = 2'b00;
    logic        s_busy, s_done;
    logic [31:0] s_res;
    logic [4:0]  s_flags;

    fp_div_generic u_dbl (
        .clk(clk), .reset(reset), .start(d_start), .fp_a_in(d_a), .fp_b_in(d_b),
        .rnd_mode(d_mode), .busy(d_busy), .done(d_done), .fp_res_out(d_res), .flags(d_flags)
    );

    fp_div_generic #(.EXP_W(8), .MAN_W(23)) u_sgl (
        .clk(clk), .reset(reset), .start(s_start), .fp_a_in(s_a), .fp_b_in(s_b),
        .rnd_mode(s_mode), .busy(s_busy), .done(s_done), .fp_res_out(s_res), .flags(s_flags)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  mode;
        logic [63:0] res;
        logic [4:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] m, input logic [63:0] r, input logic [4:0] f, input int l);
        vec_t v;
        v.name = nm; v.a = a; v.b = b; v.mode = m; v.res = r; v.flg = f; v.lat = l;
        vecs.push_back(v);
    endtask

    // Issue one double divide, scramble the inputs after acceptance, wait (bounded) for done.
    task automatic run_dbl(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m,
                           output logic [63:0] res, output logic [4:0] flg, output int lat);
        @(negedge clk);
        d_a = a; d_b = b; d_mode = m; d_start = 1'b1;
        @(posedge clk); #1;
        d_start = 1'b0; d_a = ~a; d_b = ~b; d_mode = ~m;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (d_done) begin
                lat = c;
                break;
            end
        end
        res = d_res;
        flg = d_flags;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res;
        logic [4:0]  flg;
        int          lat;
        int          npulse;

        add("div6_2",      64'h4018000000000000, 64'h4000000000000000, 2'b00, 64'h4008000000000000, 5'b00000, 59);
        add("third_rne",   64'h3FF0000000000000, 64'h4008000000000000, 2'b00, 64'h3FD5555555555555, 5'b00001, 59);
        add("third_rtz",   64'h3FF0000000000000, 64'h4008000000000000, 2'b01, 64'h3FD5555555555555, 5'b00001, 59);
        add("third_pinf",  64'h3FF0000000000000, 64'h4008000000000000, 2'b10, 64'h3FD5555555555556, 5'b00001, 59);
        add("third_ninf",  64'h3FF0000000000000, 64'h4008000000000000, 2'b11, 64'h3FD5555555555555, 5'b00001, 59);
        add("nthird_rne",  64'hBFF0000000000000, 64'h4008000000000000, 2'b00, 64'hBFD5555555555555, 5'b00001, 59);
        add("nthird_pinf", 64'hBFF0000000000000, 64'h4008000000000000, 2'b10, 64'hBFD5555555555555, 5'b00001, 59);
        add("nthird_ninf", 64'hBFF0000000000000, 64'h4008000000000000, 2'b11, 64'hBFD5555555555556, 5'b00001, 59);
        add("one_div0",    64'h3FF0000000000000, 64'h0000000000000000, 2'b00, 64'h7FF0000000000000, 5'b01000, 2);
        add("none_div0",   64'hBFF0000000000000, 64'h0000000000000000, 2'b00, 64'hFFF0000000000000, 5'b01000, 2);
        add("zero_zero",   64'h0000000000000000, 64'h0000000000000000, 2'b00, 64'h7FF8000000000000, 5'b10000, 2);
        add("snan",        64'h7FF0000000000001, 64'h3FF0000000000000, 2'b00, 64'h7FF8000000000000, 5'b10000, 2);
        add("qnan_div0",   64'h7FF8000000000000, 64'h0000000000000000, 2'b00, 64'h7FF8000000000000, 5'b00000, 2);
        add("inf_inf",     64'h7FF0000000000000, 64'hFFF0000000000000, 2'b00, 64'h7FF8000000000000, 5'b10000, 2);
        add("ninf_2",      64'hFFF0000000000000, 64'h4000000000000000, 2'b00, 64'hFFF0000000000000, 5'b00000, 2);
        add("two_ninf",    64'h4000000000000000, 64'hFFF0000000000000, 2'b00, 64'h8000000000000000, 5'b00000, 2);
        add("sub_div1",    64'h000FFFFFFFFFFFFF, 64'h3FF0000000000000, 2'b00, 64'h0000000000000000, 5'b00000, 2);
        add("one_divsub",  64'h3FF0000000000000, 64'h0000000000000001, 2'b00, 64'h7FF0000000000000, 5'b01000, 2);
        add("maxexp_ok",   64'h7FE0000000000000, 64'h3FF0000000000000, 2'b00, 64'h7FE0000000000000, 5'b00000, 59);
        add("ovf_rne",     64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 2'b00, 64'h7FF0000000000000, 5'b00101, 59);
        add("ovf_rtz",     64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 2'b01, 64'h7FEFFFFFFFFFFFFF, 5'b00101, 59);
        add("ovf_pinf",    64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 2'b10, 64'h7FF0000000000000, 5'b00101, 59);
        add("ovf_ninf",    64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 2'b11, 64'h7FEFFFFFFFFFFFFF, 5'b00101, 59);
        add("novf_pinf",   64'hFFEFFFFFFFFFFFFF, 64'h3FE0000000000000, 2'b10, 64'hFFEFFFFFFFFFFFFF, 5'b00101, 59);
        add("novf_ninf",   64'hFFEFFFFFFFFFFFFF, 64'h3FE0000000000000, 2'b11, 64'hFFF0000000000000, 5'b00101, 59);
        add("unf_pos",     64'h0010000000000000, 64'h4000000000000000, 2'b00, 64'h0000000000000000, 5'b00011, 59);
        add("unf_neg",     64'h8010000000000000, 64'h4000000000000000, 2'b00, 64'h8000000000000000, 5'b00011, 59);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_d_busy", {63'h0, d_busy}, 64'h0);
        check("rst_d_done", {63'h0, d_done}, 64'h0);
        check("rst_d_res", d_res, 64'h0);
        check("rst_d_flags", {59'h0, d_flags}, 64'h0);
        check("rst_s_res", {32'h0, s_res}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_dbl(vecs[i].a, vecs[i].b, vecs[i].mode, res, flg, lat);
            check({vecs[i].name, "_res"}, res, vecs[i].res);
            check({vecs[i].name, "_flags"}, {59'h0, flg}, {59'h0, vecs[i].flg});
            check({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
            @(posedge clk); #1;
            check({vecs[i].name, "_done_pulse"}, {63'h0, d_done}, 64'h0);
        end

        // reset in the middle of a double divide aborts it
        @(negedge clk);
        d_a = 64'h4018000000000000; d_b = 64'h4000000000000000; d_mode = 2'b00; d_start = 1'b1;
        @(posedge clk); #1;
        d_start = 1'b0;
        check("abort_busy", {63'h0, d_busy}, 64'h1);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_res", d_res, 64'h0);
        check("abort_flags", {59'h0, d_flags}, 64'h0);
        check("abort_busy0", {63'h0, d_busy}, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        npulse = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (d_done) npulse++;
        end
        check("abort_no_done", 64'(npulse), 64'h0);
        run_dbl(64'h4018000000000000, 64'h4000000000000000, 2'b00, res, flg, lat);
        check("after_abort_res", res, 64'h4008000000000000);
        check("after_abort_flags", {59'h0, flg}, 64'h0);
        check("after_abort_lat", 64'(lat), 64'd59);

        // single precision 1/3 with a start pulse while busy that must be ignored
        @(negedge clk);
        s_a = 32'h3F800000; s_b = 32'h40400000; s_mode = 2'b00; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0; s_a = 32'h40000000; s_b = 32'h3F800000; s_mode = 2'b01;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (s_done) begin
                lat = c;
                break;
            end
            if (c == 5) check("sgl_busy", {63'h0, s_busy}, 64'h1);
            s_start = (c == 5);
        end
        s_start = 1'b0;
        check("sgl_third_res", {32'h0, s_res}, 64'h3EAAAAAB);
        check("sgl_third_flags", {59'h0, s_flags}, 64'h1);
        check("sgl_third_lat", 64'(lat), 64'd30);
        npulse = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (s_done) npulse++;
        end
        check("sgl_no_extra_done", 64'(npulse), 64'h0);
        check("sgl_held_res", {32'h0, s_res}, 64'h3EAAAAAB);

        // single precision 6/2
        @(negedge clk);
        s_a = 32'h40C00000; s_b = 32'h40000000; s_mode = 2'b00; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (s_done) begin
                lat = c;
                break;
            end
        end
        check("sgl_6_2_res", {32'h0, s_res}, 64'h40400000);
        check("sgl_6_2_flags", {59'h0, s_flags}, 64'h0);
        check("sgl_6_2_lat", 64'(lat), 64'd30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
